tmr_recovery_sequencer: RTL and testbench
=========================================

# tmr_recovery_sequencer

Sequencer for the triple-modular-redundant RISC-V core cluster. It watches the voter's disagreement flags and keeps a periodic checkpoint PC. When one core is outvoted, it holds and resets all three cores, restarts them from the checkpoint, and steers memory traffic to the recovery register until execution reaches the faulting PC again. The block sits between the voter and the PC / memory-routing muxes and replaces the ad-hoc hold and select generation around them.

## Interface
Parameters:
- PC_W, 32, PC width
- RESET_PC, 32'h0, PC loaded into the checkpoint register at reset
- CKPT_INTERVAL, 16, number of fault-free NORMAL cycles between checkpoint captures (≥2)
- RST_CYCLES, 2, cycles that core_rst_n is held low per recovery (≥1)
- MAX_RETRY, 2, re-faults tolerated during replay before declaring fatal
- MAX_REPLAY, 256, replay cycle budget before declaring fatal

Ports:
- clk  in  1  system clock, rising edge
- rst_in  in  1  asynchronous, active-low reset
- voter_state  in  3  000 means all cores agree; a one-hot value names the outvoted core (bit0=A, bit1=B, bit2=C); any other value means no majority
- pc_voted  in  PC_W  majority PC from the voter
- pc_out  out  PC_W  PC forced into the cores while pc_override=1
- pc_override  out  1  selects pc_out over pc_voted at the PC mux
- core_hold  out  1  freezes all cores
- core_rst_n  out  1  active-low reset to the three cores
- recovery_mode  out  1  high during HOLD, RESET and REPLAY
- rec_wr_sel  out  1  routes MemWrite to the recovery register
- data_rec_sel  out  1  selects recovery-register read data
- fault_core  out  3  one-hot record of the last core repaired
- retry_cnt  out  2  re-faults during the current recovery
- fatal  out  1  sticky; cleared only by reset

## Operation
States are NORMAL, HOLD, RESET, REPLAY and FAIL.

Outputs are decoded from registered state, so each output changes on the edge that enters its state.

- NORMAL
  - All control outputs are low, except core_rst_n=1.
  - Each cycle with voter_state==000 increments ckpt_cnt. At CKPT_INTERVAL-1: ckpt_pc<=pc_voted and ckpt_cnt<=0.
  - voter_state one-hot: fault_pc<=pc_voted, fault_core<=voter_state, next state HOLD. The checkpoint is not updated that cycle.
  - voter_state with no majority: next state FAIL.
- HOLD
  - core_hold=1 for exactly 1 cycle, then RESET.
- RESET
  - core_hold=1, core_rst_n=0, pc_override=1, pc_out=ckpt_pc.
  - Lasts RST_CYCLES cycles, counted by a down-counter, then REPLAY.
- REPLAY
  - rec_wr_sel=1, data_rec_sel=1, pc_override=0, core_hold=0.
  - replay_cnt increments every cycle.
  - voter_state==000 and pc_voted==fault_pc: next state NORMAL; retry_cnt<=0, replay_cnt<=0, ckpt_cnt<=0.
  - voter_state one-hot:
    - If retry_cnt<MAX_RETRY: retry_cnt++, fault_core<=voter_state, next state HOLD. fault_pc is kept.
    - Otherwise: next state FAIL.
  - voter_state with no majority, or replay_cnt==MAX_REPLAY-1: next state FAIL.
- FAIL
  - fatal=1, core_hold=1, core_rst_n=0, recovery_mode=0.
  - Terminal until rst_in is asserted.

Precedence within a cycle, highest first:
1. No majority
2. Fault
3. Exit match

This means a fault in the same cycle as a PC match re-enters HOLD.

## Timing
- Reset values:
  - state=NORMAL
  - ckpt_pc=RESET_PC, pc_out=RESET_PC
  - ckpt_cnt=0, retry_cnt=0
  - fault_core=000
  - core_rst_n=1, and all other outputs 0
- Latency from a fault sample to core_hold=1 is 1 cycle.
- A single-fault recovery spends 1+RST_CYCLES cycles in HOLD and RESET before REPLAY.
- Asserting rst_in mid-recovery aborts it immediately. The checkpoint reverts to RESET_PC.
- The PC-match comparison is a full PC_W equality compare. There is no wrap handling.

## Structure
- Package tmr_pkg holds:
  - the state enum
  - voter_state encodings VS_AGREE, VS_A, VS_B, VS_C
  - the one-hot check function
- Sub-module tmr_ckpt_tracker holds ckpt_cnt and ckpt_pc. Its inputs are enable (NORMAL && agree), clear, and pc_voted; its output is ckpt_pc.

## Test plan
- Checkpoint capture: with CKPT_INTERVAL=4 and fault-free pc_voted=0,4,8,12,16 → ckpt_pc=12 after the 4th cycle.
- Single fault: voter_state=010 at pc_voted=0x40 with ckpt_pc=0x30 → HOLD for 1 cycle, core_rst_n low for 2 cycles with pc_out=0x30, then REPLAY with rec_wr_sel=data_rec_sel=1. pc_voted=0x40 with 000 → NORMAL, fault_core=010.
- Re-fault during replay: voter_state=001 twice during REPLAY → retry_cnt=1, then 2 with HOLD re-entered each time. A third fault → FAIL with fatal=1.
- No majority: voter_state=011 in NORMAL → FAIL on the next edge; fatal stays high until rst_in is asserted.
- Replay timeout: with MAX_REPLAY=8 and pc_voted never reaching fault_pc → FAIL after 8 REPLAY cycles.
- Reset during RESET state: rst_in pulsed low → all outputs at their reset values asynchronously, ckpt_pc=RESET_PC.

Source files
------------

// File: rtl/tmr_recovery_sequencer_pkg.sv
// rtl/tmr_recovery_sequencer_pkg.sv - shared types and helpers for the TMR recovery sequencer
// State encoding, voter_state encodings and the control-output decode used by the sequencer.
package tmr_pkg;

  typedef enum logic [2:0] {
    ST_NORMAL = 3'd0,
    ST_HOLD   = 3'd1,
    ST_RESET  = 3'd2,
    ST_REPLAY = 3'd3,
    ST_FAIL   = 3'd4
  } tmr_state_e;

  localparam logic [2:0] VS_AGREE = 3'b000;
  localparam logic [2:0] VS_A     = 3'b001;
  localparam logic [2:0] VS_B     = 3'b010;
  localparam logic [2:0] VS_C     = 3'b100;

  typedef struct packed {
    logic core_hold;
    logic core_rst_n;
    logic pc_override;
    logic recovery_mode;
    logic rec_wr_sel;
    logic data_rec_sel;
    logic fatal;
  } tmr_ctrl_t;

  function automatic logic is_one_hot(input logic [2:0] vs);
    return (vs == VS_A) || (vs == VS_B) || (vs == VS_C);
  endfunction

  // Control outputs are a pure function of the state being entered.
  function automatic tmr_ctrl_t decode_ctrl(input tmr_state_e st);
    tmr_ctrl_t c;
    c = '{core_hold: 1'b0, core_rst_n: 1'b1, pc_override: 1'b0, recovery_mode: 1'b0,
          rec_wr_sel: 1'b0, data_rec_sel: 1'b0, fatal: 1'b0};
    case (st)
      ST_HOLD: begin
        c.core_hold     = 1'b1;
        c.recovery_mode = 1'b1;
      end
      ST_RESET: begin
        c.core_hold     = 1'b1;
        c.core_rst_n    = 1'b0;
        c.pc_override   = 1'b1;
        c.recovery_mode = 1'b1;
      end
      ST_REPLAY: begin
        c.recovery_mode = 1'b1;
        c.rec_wr_sel    = 1'b1;
        c.data_rec_sel  = 1'b1;
      end
      ST_FAIL: begin
        c.core_hold  = 1'b1;
        c.core_rst_n = 1'b0;
        c.fatal      = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/tmr_recovery_sequencer_if.sv
// rtl/tmr_recovery_sequencer_if.sv - voter / core-control bundle for the TMR recovery sequencer
// master = sequencer side, slave = voter / mux side.
interface tmr_recovery_sequencer_if #(
  parameter int PC_W = 32
);
  logic [2:0]      voter_state;
  logic [PC_W-1:0] pc_voted;
  logic [PC_W-1:0] pc_out;
  logic            pc_override;
  logic            core_hold;
  logic            core_rst_n;
  logic            recovery_mode;
  logic            rec_wr_sel;
  logic            data_rec_sel;
  logic [2:0]      fault_core;
  logic [1:0]      retry_cnt;
  logic            fatal;

  modport master (
    input  voter_state, pc_voted,
    output pc_out, pc_override, core_hold, core_rst_n, recovery_mode,
           rec_wr_sel, data_rec_sel, fault_core, retry_cnt, fatal
  );

  modport slave (
    output voter_state, pc_voted,
    input  pc_out, pc_override, core_hold, core_rst_n, recovery_mode,
           rec_wr_sel, data_rec_sel, fault_core, retry_cnt, fatal
  );
endinterface

// File: rtl/tmr_recovery_sequencer_ckpt_tracker.sv
// rtl/tmr_recovery_sequencer_ckpt_tracker.sv - periodic checkpoint PC capture
// Captures pc_voted every CKPT_INTERVAL enabled cycles; clear restarts the interval.
module tmr_ckpt_tracker #(
  parameter int              PC_W          = 32,
  parameter logic [PC_W-1:0] RESET_PC      = '0,
  parameter int              CKPT_INTERVAL = 16
) (
  input  logic            clk,
  input  logic            rst_in,
  input  logic            enable,
  input  logic            clear,
  input  logic [PC_W-1:0] pc_voted,
  output logic [PC_W-1:0] ckpt_pc
);

  localparam int                CNT_W    = $clog2(CKPT_INTERVAL);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CKPT_INTERVAL - 1);

  logic [CNT_W-1:0] ckpt_cnt_q, ckpt_cnt_d;
  logic [PC_W-1:0]  ckpt_pc_q, ckpt_pc_d;

  always_comb begin
    ckpt_cnt_d = ckpt_cnt_q;
    ckpt_pc_d  = ckpt_pc_q;
    if (clear) begin
      ckpt_cnt_d = '0;
    end else if (enable) begin
      if (ckpt_cnt_q == CNT_LAST) begin
        ckpt_cnt_d = '0;
        ckpt_pc_d  = pc_voted;
      end else begin
        ckpt_cnt_d = ckpt_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      ckpt_cnt_q <= '0;
      ckpt_pc_q  <= RESET_PC;
    end else begin
      ckpt_cnt_q <= ckpt_cnt_d;
      ckpt_pc_q  <= ckpt_pc_d;
    end
  end

  assign ckpt_pc = ckpt_pc_q;

endmodule

// File: rtl/tmr_recovery_sequencer.sv
// rtl/tmr_recovery_sequencer.sv - hold / reset / replay sequencer for the TMR core cluster
// Repairs an outvoted core by restarting all three from the last checkpoint PC.
module tmr_recovery_sequencer
  import tmr_pkg::*;
#(
  parameter int              PC_W          = 32,
  parameter logic [PC_W-1:0] RESET_PC      = '0,
  parameter int              CKPT_INTERVAL = 16,
  parameter int              RST_CYCLES    = 2,
  parameter int              MAX_RETRY     = 2,
  parameter int              MAX_REPLAY    = 256
) (
  input  logic                       clk,
  input  logic                       rst_in,
  tmr_recovery_sequencer_if.master   bus
);

  localparam int               RST_W    = $clog2(RST_CYCLES + 1);
  localparam int               RP_W     = $clog2(MAX_REPLAY + 1);
  localparam logic [RST_W-1:0] RST_LOAD = RST_W'(RST_CYCLES - 1);
  localparam logic [RP_W-1:0]  RP_LAST  = RP_W'(MAX_REPLAY - 1);

  tmr_state_e       state_q, state_d;
  logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [RP_W-1:0]  replay_cnt_q, replay_cnt_d;
  logic [1:0]       retry_cnt_q, retry_cnt_d;
  logic [PC_W-1:0]  fault_pc_q, fault_pc_d;
  logic [2:0]       fault_core_q, fault_core_d;
  tmr_ctrl_t        ctrl_q, ctrl_d;

  logic            agree, fault, no_maj;
  logic            ckpt_en, ckpt_clear;
  logic [PC_W-1:0] ckpt_pc;

  assign agree   = (bus.voter_state == VS_AGREE);
  assign fault   = is_one_hot(bus.voter_state);
  assign no_maj  = !agree && !fault;
  assign ckpt_en = (state_q == ST_NORMAL) && agree;

  tmr_ckpt_tracker #(
    .PC_W          (PC_W),
    .RESET_PC      (RESET_PC),
    .CKPT_INTERVAL (CKPT_INTERVAL)
  ) u_ckpt (
    .clk      (clk),
    .rst_in   (rst_in),
    .enable   (ckpt_en),
    .clear    (ckpt_clear),
    .pc_voted (bus.pc_voted),
    .ckpt_pc  (ckpt_pc)
  );

  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    replay_cnt_d = replay_cnt_q;
    retry_cnt_d  = retry_cnt_q;
    fault_pc_d   = fault_pc_q;
    fault_core_d = fault_core_q;
    ckpt_clear   = 1'b0;

    case (state_q)
      ST_NORMAL: begin
        if (no_maj) begin
          state_d = ST_FAIL;
        end else if (fault) begin
          fault_pc_d   = bus.pc_voted;
          fault_core_d = bus.voter_state;
          state_d      = ST_HOLD;
        end
      end
      ST_HOLD: begin
        state_d   = ST_RESET;
        rst_cnt_d = RST_LOAD;
      end
      ST_RESET: begin
        if (rst_cnt_q == '0) begin
          state_d      = ST_REPLAY;
          replay_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q - 1'b1;
        end
      end
      ST_REPLAY: begin
        replay_cnt_d = replay_cnt_q + 1'b1;
        // A re-fault wins over reaching the faulting PC in the same cycle.
        if (no_maj || (replay_cnt_q == RP_LAST)) begin
          state_d = ST_FAIL;
        end else if (fault) begin
          if (int'(retry_cnt_q) < MAX_RETRY) begin
            retry_cnt_d  = retry_cnt_q + 1'b1;
            fault_core_d = bus.voter_state;
            state_d      = ST_HOLD;
          end else begin
            state_d = ST_FAIL;
          end
        end else if (bus.pc_voted == fault_pc_q) begin
          state_d      = ST_NORMAL;
          retry_cnt_d  = '0;
          replay_cnt_d = '0;
          ckpt_clear   = 1'b1;
        end
      end
      ST_FAIL: state_d = ST_FAIL;
      default: state_d = ST_FAIL;
    endcase

    ctrl_d = decode_ctrl(state_d);
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= ST_NORMAL;
      rst_cnt_q    <= '0;
      replay_cnt_q <= '0;
      retry_cnt_q  <= '0;
      fault_pc_q   <= '0;
      fault_core_q <= '0;
      ctrl_q       <= decode_ctrl(ST_NORMAL);
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      replay_cnt_q <= replay_cnt_d;
      retry_cnt_q  <= retry_cnt_d;
      fault_pc_q   <= fault_pc_d;
      fault_core_q <= fault_core_d;
      ctrl_q       <= ctrl_d;
    end
  end

  assign bus.pc_out        = ckpt_pc;
  assign bus.pc_override   = ctrl_q.pc_override;
  assign bus.core_hold     = ctrl_q.core_hold;
  assign bus.core_rst_n    = ctrl_q.core_rst_n;
  assign bus.recovery_mode = ctrl_q.recovery_mode;
  assign bus.rec_wr_sel    = ctrl_q.rec_wr_sel;
  assign bus.data_rec_sel  = ctrl_q.data_rec_sel;
  assign bus.fault_core    = fault_core_q;
  assign bus.retry_cnt     = retry_cnt_q;
  assign bus.fatal         = ctrl_q.fatal;

endmodule

// File: tb/tb_tmr_recovery_sequencer.sv
// tb/tb_tmr_recovery_sequencer.sv - scoreboard bench for tmr_recovery_sequencer
module tb_tmr_recovery_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic clk    = 1'b0;
  logic rst_in = 1'b1;

  tmr_recovery_sequencer_if #(.PC_W(32)) bus ();

  tmr_recovery_sequencer #(
    .PC_W          (32),
    .RESET_PC      (RST_PC),
    .CKPT_INTERVAL (4),
    .RST_CYCLES    (2),
    .MAX_RETRY     (2),
    .MAX_REPLAY    (8)
  ) dut (
    .clk    (clk),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef enum {E_N, E_H, E_R, E_P, E_F} est_e;

  typedef struct {
    logic [6:0]  ctrl;
    logic [31:0] pc;
    logic [2:0]  fc;
    logic [1:0]  rc;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // {core_hold, core_rst_n, pc_override, recovery_mode, rec_wr_sel, data_rec_sel, fatal}
  function automatic logic [6:0] ctrl_of(input est_e s);
    case (s)
      E_N:     return 7'b0100000;
      E_H:     return 7'b1101000;
      E_R:     return 7'b1011000;
      E_P:     return 7'b0101110;
      default: return 7'b1000001;
    endcase
  endfunction

  task automatic push(input est_e s, input logic [31:0] pco, input logic [2:0] fc,
                      input logic [1:0] rc, input string nm);
    exp_t e;
    e.ctrl = ctrl_of(s);
    e.pc   = pco;
    e.fc   = fc;
    e.rc   = rc;
    e.name = nm;
    q.push_back(e);
  endtask

  // Called at a negedge: drive one cycle of inputs, expect outputs after the next posedge.
  task automatic step(input logic [2:0] vs, input logic [31:0] pc, input est_e s,
                      input logic [31:0] pco, input logic [2:0] fc, input logic [1:0] rc,
                      input string nm);
    bus.voter_state = vs;
    bus.pc_voted    = pc;
    push(s, pco, fc, rc, nm);
    @(negedge clk);
  endtask

  // Called at a negedge: reset asserted while clk is low, checked before any posedge.
  task automatic rpulse(input string nm);
    push(E_N, RST_PC, 3'b000, 2'd0, nm);
    #2 rst_in = 1'b0;
    @(negedge clk);
    rst_in          = 1'b1;
    bus.voter_state = 3'b000;
    bus.pc_voted    = '0;
  endtask

  initial begin : monitor
    exp_t        e;
    logic [43:0] act, expv;
    forever begin
      @(posedge clk or negedge rst_in);
      #1;
      if (q.size() > 0) begin
        e    = q.pop_front();
        act  = {bus.core_hold, bus.core_rst_n, bus.pc_override, bus.recovery_mode,
                bus.rec_wr_sel, bus.data_rec_sel, bus.fatal, bus.pc_out, bus.fault_core,
                bus.retry_cnt};
        expv = {e.ctrl, e.pc, e.fc, e.rc};
        checks++;
        if (act !== expv) begin
          failures++;
          $display("FAIL %s: ctrl/pc_out/fault_core/retry got %b/%h/%b/%0d want %b/%h/%b/%0d",
                   e.name, act[43:37], act[36:5], act[4:2], act[1:0],
                   e.ctrl, e.pc, e.fc, e.rc);
        end
      end
    end
  end

  initial begin : stim
    bus.voter_state = 3'b000;
    bus.pc_voted    = '0;
    @(negedge clk);
    rpulse("reset_init");

    step(3'b000, 32'h00, E_N, RST_PC, 3'b000, 2'd0, "ckpt_c0");
    step(3'b000, 32'h04, E_N, RST_PC, 3'b000, 2'd0, "ckpt_c1");
    step(3'b000, 32'h08, E_N, RST_PC, 3'b000, 2'd0, "ckpt_c2");
    step(3'b000, 32'h0C, E_N, 32'h0C, 3'b000, 2'd0, "ckpt_capture");
    step(3'b000, 32'h10, E_N, 32'h0C, 3'b000, 2'd0, "ckpt_keep");
    step(3'b000, 32'h20, E_N, 32'h0C, 3'b000, 2'd0, "ckpt_c1b");
    step(3'b000, 32'h28, E_N, 32'h0C, 3'b000, 2'd0, "ckpt_c2b");
    step(3'b000, 32'h30, E_N, 32'h30, 3'b000, 2'd0, "ckpt_capture2");

    step(3'b010, 32'h40, E_H, 32'h30, 3'b010, 2'd0, "flt_hold");
    step(3'b000, 32'h40, E_R, 32'h30, 3'b010, 2'd0, "flt_reset0");
    step(3'b000, 32'h40, E_R, 32'h30, 3'b010, 2'd0, "flt_reset1");
    step(3'b000, 32'h30, E_P, 32'h30, 3'b010, 2'd0, "flt_replay");
    step(3'b000, 32'h30, E_P, 32'h30, 3'b010, 2'd0, "rp_nomatch");
    step(3'b000, 32'h40, E_N, 32'h30, 3'b010, 2'd0, "rp_exit");

    step(3'b001, 32'h50, E_H, 32'h30, 3'b001, 2'd0, "rf_hold");
    step(3'b000, 32'h50, E_R, 32'h30, 3'b001, 2'd0, "rf_reset0");
    step(3'b000, 32'h50, E_R, 32'h30, 3'b001, 2'd0, "rf_reset1");
    step(3'b000, 32'h34, E_P, 32'h30, 3'b001, 2'd0, "rf_replay");
    step(3'b001, 32'h50, E_H, 32'h30, 3'b001, 2'd1, "rf1_fault_beats_match");
    step(3'b000, 32'h50, E_R, 32'h30, 3'b001, 2'd1, "rf1_reset0");
    step(3'b000, 32'h50, E_R, 32'h30, 3'b001, 2'd1, "rf1_reset1");
    step(3'b000, 32'h34, E_P, 32'h30, 3'b001, 2'd1, "rf1_replay");
    step(3'b001, 32'h38, E_H, 32'h30, 3'b001, 2'd2, "rf2_hold");
    step(3'b000, 32'h38, E_R, 32'h30, 3'b001, 2'd2, "rf2_reset0");
    step(3'b000, 32'h38, E_R, 32'h30, 3'b001, 2'd2, "rf2_reset1");
    step(3'b000, 32'h38, E_P, 32'h30, 3'b001, 2'd2, "rf2_replay");
    step(3'b100, 32'h38, E_F, 32'h30, 3'b001, 2'd2, "rf3_fatal");
    step(3'b000, 32'h50, E_F, 32'h30, 3'b001, 2'd2, "fatal_sticky");
    rpulse("reset_clears_fatal");

    step(3'b000, 32'h00, E_N, RST_PC, 3'b000, 2'd0, "nm_pre");
    step(3'b011, 32'h08, E_F, RST_PC, 3'b000, 2'd0, "nm_fail");
    step(3'b000, 32'h08, E_F, RST_PC, 3'b000, 2'd0, "nm_sticky0");
    step(3'b000, 32'h08, E_F, RST_PC, 3'b000, 2'd0, "nm_sticky1");
    rpulse("reset_after_nm");

    step(3'b000, 32'h00, E_N, RST_PC, 3'b000, 2'd0, "to_pre");
    step(3'b100, 32'h80, E_H, RST_PC, 3'b100, 2'd0, "to_hold");
    step(3'b000, 32'h80, E_R, RST_PC, 3'b100, 2'd0, "to_reset0");
    step(3'b000, 32'h80, E_R, RST_PC, 3'b100, 2'd0, "to_reset1");
    step(3'b000, 32'h10, E_P, RST_PC, 3'b100, 2'd0, "to_replay");
    for (int i = 0; i < 7; i++)
      step(3'b000, 32'h10, E_P, RST_PC, 3'b100, 2'd0, "to_replay_run");
    step(3'b000, 32'h10, E_F, RST_PC, 3'b100, 2'd0, "to_timeout");
    rpulse("reset_after_timeout");

    step(3'b000, 32'h00, E_N, RST_PC, 3'b000, 2'd0, "mid_c0");
    step(3'b000, 32'h04, E_N, RST_PC, 3'b000, 2'd0, "mid_c1");
    step(3'b000, 32'h08, E_N, RST_PC, 3'b000, 2'd0, "mid_c2");
    step(3'b000, 32'h0C, E_N, 32'h0C, 3'b000, 2'd0, "mid_capture");
    step(3'b001, 32'h44, E_H, 32'h0C, 3'b001, 2'd0, "mid_hold");
    step(3'b000, 32'h44, E_R, 32'h0C, 3'b001, 2'd0, "mid_reset");
    rpulse("reset_mid_recovery");
    step(3'b000, 32'h00, E_N, RST_PC, 3'b000, 2'd0, "post_reset");

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
